// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front-end controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } sw_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_DB_W = 20;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce
// counter and a one-cycle press pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic meta;
  logic s;
  logic deb;
  logic deb_q;
  logic p_q;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      s       <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      p_q     <= 1'b0;
      pressed <= 1'b0;
      cnt     <= '0;
    end else begin
      meta <= btn_raw;
      s    <= meta;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      deb_q <= deb;
      // Edge pulse leaves through two flops to meet the press latency.
      p_q     <= deb & ~deb_q;
      pressed <= p_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM: conditions three buttons and drives the digit
// counter's run, one-cycle clear and lap display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DB_W = DEFAULT_DB_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       run,
  output logic       clear_cnt,
  output logic       display_freeze,
  output logic [1:0] state_o
);

  logic ss_p;
  logic clr_p;
  logic lap_p;
  logic take_clr;
  sw_state_t state;
  sw_state_t nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_ss (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_start_stop),
    .pressed(ss_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_clr (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_clear),
    .pressed(clr_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_lap (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_lap),
    .pressed(lap_p)
  );

  // Highest-priority legal press wins; the rest are dropped.
  always_comb begin
    nxt      = state;
    take_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_p) take_clr = 1'b1;
        else if (ss_p) nxt = RUNNING;
      end
      RUNNING: begin
        if (ss_p) nxt = PAUSED;
        else if (lap_p) nxt = LAP;
      end
      PAUSED: begin
        if (clr_p) begin
          nxt      = IDLE;
          take_clr = 1'b1;
        end else if (ss_p) begin
          nxt = RUNNING;
        end
      end
      LAP: begin
        if (ss_p) nxt = PAUSED;
        else if (lap_p) nxt = RUNNING;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      run            <= 1'b0;
      display_freeze <= 1'b0;
      clear_cnt      <= 1'b0;
    end else begin
      state          <= nxt;
      run            <= (nxt == RUNNING) || (nxt == LAP);
      display_freeze <= (nxt == LAP);
      clear_cnt      <= take_clr;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button
// traffic against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic run;
  logic clear_cnt;
  logic display_freeze;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .DB_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start_stop(btn[0]),
    .btn_clear(btn[1]),
    .btn_lap(btn[2]),
    .run(run),
    .clear_cnt(clear_cnt),
    .display_freeze(display_freeze),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Model. Button index: 0 start/stop, 1 clear, 2 lap.
  // A level is accepted after DC consecutive edges where the
  // synchronized input (raw from two edges back) disagrees with it;
  // the FSM acts on a press three edges after acceptance.
  bit h1 [3];
  bit h2 [3];
  bit mdeb [3];
  int mlen [3];
  logic [2:0] d1 = '0;
  logic [2:0] d2 = '0;
  logic [2:0] d3 = '0;
  int mstate = 0;
  bit mclr = 0;
  // next state per [state][button], -1 = press ignored
  int nxt_tab [4][3] = '{'{1, 0, -1}, '{2, -1, 3},
                         '{1, 0, -1}, '{2, -1, 1}};
  int ord [3] = '{1, 0, 2};

  initial begin : model
    logic [2:0] fire;
    int b;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          h1[i] = 0; h2[i] = 0; mdeb[i] = 0; mlen[i] = 0;
        end
        d1 = '0; d2 = '0; d3 = '0;
        mstate = 0; mclr = 0;
      end else begin
        fire = d3; d3 = d2; d2 = d1; d1 = '0;
        for (int i = 0; i < 3; i++) begin
          if (h2[i] != mdeb[i]) begin
            mlen[i]++;
            if (mlen[i] == DC) begin
              mdeb[i] = h2[i];
              mlen[i] = 0;
              if (h2[i]) d1[i] = 1'b1;
            end
          end else begin
            mlen[i] = 0;
          end
          h2[i] = h1[i];
          h1[i] = btn[i];
        end
        mclr = 0;
        for (int i = 0; i < 3; i++) begin
          b = ord[i];
          if (fire[b] && nxt_tab[mstate][b] >= 0) begin
            if (b == 1) mclr = 1;
            mstate = nxt_tab[mstate][b];
            break;
          end
        end
      end
    end
  end

  function automatic logic [4:0] exp_obs();
    logic [1:0] st;
    st = 2'(mstate);
    return {st[0], st == 2'b11, mclr, st};
  endfunction

  function automatic logic [4:0] obs();
    return {run, display_freeze, clear_cnt, state_o};
  endfunction

  task automatic press(input logic [2:0] m, output int nclr,
                       output int nrun, output logic [1:0] st_clr);
    nclr = 0; nrun = 0; st_clr = 2'b11;
    btn = m;
    for (int k = 0; k < 24; k++) begin
      if (k == 10) btn = 3'b000;
      @(negedge clk);
      if (clear_cnt) begin
        nclr++;
        st_clr = state_o;
      end
      if (run) nrun++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 5'b00000)
      $display("FAIL reset_state obs=%b exp=%b", obs(), 5'b00000);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== exp_obs())
      $display("FAIL reset_model obs=%b exp=%b", obs(), exp_obs());
    if (obs() !== 5'b00000 || obs() !== exp_obs()) errors++;
  endtask

  task automatic test_start();
    int rise;
    rise = -1;
    btn[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (run && rise < 0) rise = k;
    end
    checks++;
    if (rise != 8) begin
      errors++;
      $display("FAIL ss_latency run_rise=%0d exp=8", rise);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (obs() !== 5'b10001 || obs() !== exp_obs()) begin
      errors++;
      $display("FAIL ss_held obs=%b exp=%b", obs(), 5'b10001);
    end
    btn = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_lap();
    int nc, nr;
    logic [1:0] sc;
    for (int i = 0; i < 4; i++) begin
      btn[2] = (i % 2 == 0);
      @(negedge clk);
    end
    btn = 3'b000;
    repeat (12) @(negedge clk);
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL lap_bounce obs=%b exp=%b", obs(), 5'b10001);
    end
    press(3'b100, nc, nr, sc);
    checks++;
    if (obs() !== 5'b11011 || obs() !== exp_obs()) begin
      errors++;
      $display("FAIL lap_enter obs=%b exp=%b", obs(), 5'b11011);
    end
    press(3'b100, nc, nr, sc);
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL lap_exit obs=%b exp=%b", obs(), 5'b10001);
    end
  endtask

  task automatic test_pause_clear();
    int nc, nr;
    logic [1:0] sc;
    press(3'b001, nc, nr, sc);
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL pause obs=%b exp=%b", obs(), 5'b00010);
    end
    press(3'b010, nc, nr, sc);
    checks++;
    if (nc != 1 || sc !== 2'b00 || obs() !== 5'b00000) begin
      errors++;
      $display("FAIL pause_clear clr_cycles=%0d st=%b obs=%b exp=1 00 %b",
               nc, sc, obs(), 5'b00000);
    end
  endtask

  task automatic test_clear_ignored();
    int nc, nr;
    logic [1:0] sc;
    press(3'b001, nc, nr, sc);
    press(3'b010, nc, nr, sc);
    checks++;
    if (nc != 0 || obs() !== 5'b10001) begin
      errors++;
      $display("FAIL clr_in_run clr_cycles=%0d obs=%b exp=0 %b",
               nc, obs(), 5'b10001);
    end
  endtask

  task automatic test_simultaneous();
    int nc, nr;
    logic [1:0] sc;
    press(3'b001, nc, nr, sc);
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL sim_pause obs=%b exp=%b", obs(), 5'b00010);
    end
    press(3'b011, nc, nr, sc);
    checks++;
    if (nc != 1 || nr != 0 || obs() !== 5'b00000) begin
      errors++;
      $display("FAIL clr_over_ss clr=%0d run=%0d obs=%b exp=1 0 %b",
               nc, nr, obs(), 5'b00000);
    end
  endtask

  task automatic test_reset_mid();
    int nc, nr, rise;
    logic [1:0] sc;
    press(3'b001, nc, nr, sc);
    press(3'b100, nc, nr, sc);
    checks++;
    if (obs() !== 5'b11011) begin
      errors++;
      $display("FAIL pre_reset_lap obs=%b exp=%b", obs(), 5'b11011);
    end
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs(), 5'b00000);
    end
    @(negedge clk);
    reset = 1'b0;
    rise = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (run && rise < 0) rise = k;
    end
    checks++;
    if (rise != 8) begin
      errors++;
      $display("FAIL reset_redebounce run_rise=%0d exp=8", rise);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (obs() !== 5'b10001 || obs() !== exp_obs()) begin
      errors++;
      $display("FAIL reset_held obs=%b exp=%b", obs(), 5'b10001);
    end
    btn = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int left;
    logic [2:0] pick;
    left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (left == 0) begin
        pick = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) pick = 3'b001 << $urandom_range(0, 2);
        if ($urandom_range(0, 4) == 0) pick = 3'b000;
        btn = pick;
        left = $urandom_range(1, 12);
      end
      left--;
      @(negedge clk);
      checks++;
      if (obs() !== exp_obs()) begin
        errors++;
        $display("FAIL random_cycle%0d obs=%b exp=%b", n, obs(), exp_obs());
      end
    end
    btn = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_clear();
    test_clear_ignored();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
